day4_scan_sequencer: RTL and testbench
======================================

# day4_scan_sequencer

Controller that sweeps an inclusive candidate range through the Day 4 password-checker datapath one value at a time. It sequences candidate issue, waits for each check result, and accumulates the pass count. It sits between the range inputs and the checker, and raises `done` with the final count. The sweep can launch itself one tick after reset; this is the startup condition the existing first-tick logic provides.

## Interface
Parameters:
- `CAND_W`, default 20: candidate and range width; 999999 < 2^20.
- `CNT_W`, default 20: pass-counter width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset. Asynchronous assert, active-low.
- `start`, in, 1: launch request; sampled only in IDLE and DONE.
- `range_lo`, in, CAND_W: first candidate; latched in LOAD.
- `range_hi`, in, CAND_W: last candidate, inclusive; latched in LOAD.
- `cand`, out, CAND_W: candidate presented to the checker.
- `cand_valid`, out, 1: `cand` is valid.
- `cand_ready`, in, 1: checker accepts `cand`.
- `res_valid`, in, 1: checker result strobe.
- `res_pass`, in, 1: result value; qualified by `res_valid`.
- `busy`, out, 1: high in LOAD, ISSUE and WAIT.
- `done`, out, 1: sweep complete; held high until the next launch.
- `error`, out, 1: latched range error (`range_lo > range_hi`).
- `pass_count`, out, CNT_W: accumulated passes; held stable in DONE.

## Operation
- States are IDLE, LOAD, ISSUE, WAIT and DONE.
- IDLE: `start` moves the FSM to LOAD.
- LOAD:
  - Latches `lo` and `hi`, sets `cur = lo`, clears `pass_count` and `error`.
  - If `lo > hi`: sets `error = 1` and goes to DONE with count 0.
  - Otherwise goes to ISSUE.
- ISSUE:
  - Drives `cand_valid = 1` and `cand = cur`.
  - A transfer happens when `cand_valid & cand_ready`; the FSM then goes to WAIT.
  - `cand` stays stable while it is not accepted.
- WAIT:
  - `cand_valid = 0`. On `res_valid`, `pass_count += res_pass`.
  - If `cur == hi`, goes to DONE. Otherwise `cur <= cur + 1` and the FSM returns to ISSUE.
- DONE:
  - `done = 1`.
  - `start` moves the FSM to LOAD; `done` drops in the LOAD cycle.
  - The ranges are re-latched, so a new range may be applied between runs.
- `pass_count` saturates at all-ones and never wraps; a full 2^20 range can produce 2^20 passes.
- `cur` increments only when `cur != hi`, so it never wraps, including when `hi` is all-ones.
- `res_valid` outside WAIT is ignored; no count change.
- `start` while busy is ignored.
- Reset at any point aborts the sweep. All state returns to reset values; no partial count is retained.

## Timing
- Reset values:
  - State is IDLE.
  - `cand` = 0, `cand_valid` = 0, `busy` = 0, `done` = 0, `error` = 0, `pass_count` = 0.
- All outputs are registered or decoded from state and registers only; there is no combinational path from inputs to outputs.
- Launch latency: `start` in cycle t gives LOAD in t+1 and the first `cand_valid` in t+2.
- Throughput: with `cand_ready` and `res_valid` both held high, one candidate per 2 cycles.
  - N candidates take 1 + 2N cycles from LOAD to DONE.
  - `done` rises the cycle after the last `res_valid`.
- `pass_count` updates the cycle after the qualifying `res_valid`. It is final when `done` rises.
- At most one outstanding candidate; the checker must not return a result before accepting the candidate.

## Configuration
- `SCAN_AUTOSTART_EN`:
  - Defined: an internal first-tick pulse is high for exactly the first clock after `rst` deasserts. It acts as a one-shot `start` in IDLE, so LOAD occurs in cycle 2 after release. The external `start` remains functional.
  - Undefined: no pulse; the sequencer waits in IDLE for `start`.

## Structure
- Shared package `day4_pkg`:
  - State enum `scan_state_t` (IDLE, LOAD, ISSUE, WAIT, DONE).
  - Constants `DAY4_CAND_W = 20` and `DAY4_CNT_W = 20`.
- Sub-module `first_tick_pulse`:
  - Asynchronous active-low reset; output is high on the first clock after reset, then low forever.
  - Instantiated only under `SCAN_AUTOSTART_EN`.
- Everything else is one flat FSM plus the counter and compare logic in `day4_scan_sequencer`.

## Test plan
- **Single-value range:** range 5..5, checker passes, zero latency → one candidate `cand = 5`; `pass_count = 1`; `done` 3 cycles after LOAD; `error = 0`.
- **Inverted range:** range 10..3 → DONE directly after LOAD; `error = 1`, `pass_count = 0`, `cand_valid` never asserted.
- **Backpressure:**
  - Range 111110..111112, with a model checker passing only 111111.
  - `cand_ready` is held low 4 cycles per candidate, and `res_valid` delayed 3 cycles.
  - Required: `cand` stable while stalled; `cand` values exactly 111110, 111111, 111112 in order; `pass_count = 1`.
- **Stray inputs:**
  - `res_valid` pulses in ISSUE and DONE leave the count unchanged.
  - `start` during WAIT is ignored.
  - After `done`, a new `start` with range 0..1 and pass-all gives `pass_count = 2`.
- **Reset mid-sweep:** `rst` asserted in WAIT of range 0..100 → all outputs go to reset values immediately (asynchronously). After release, IDLE holds, or, with `SCAN_AUTOSTART_EN`, LOAD occurs in cycle 2.
- **Saturation:** force `CNT_W = 2`, range 0..7, pass-all → `pass_count` sticks at 3; `done` still asserts after candidate 7.

Source files
------------

// File: rtl/day4_pkg.sv
// Shared types and constants for the Day 4 password-checker sweep.
package day4_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      ISSUE = 3'd2,
      WAIT  = 3'd3,
      DONE  = 3'd4
   } scan_state_t;

   localparam int DAY4_CAND_W = 20;
   localparam int DAY4_CNT_W  = 20;

endpackage

// File: rtl/day4_scan_sequencer_first_tick_pulse.sv
// One-shot pulse: high from reset release until the first rising clock edge,
// then low until the next reset. Used as an automatic launch request.
module first_tick_pulse (
   input  logic clk,
   input  logic rst,
   output logic pulse
);

   logic armed;

   // Armed by reset, disarmed permanently by the first clock edge after release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) armed <= 1'b1;
      else      armed <= 1'b0;
   end

   assign pulse = armed;

endmodule

// File: rtl/day4_scan_sequencer.sv
// Sweeps an inclusive candidate range through the Day 4 checker, one value
// at a time, and accumulates a saturating pass count.
// Optional feature: define SCAN_AUTOSTART_EN to launch one sweep automatically
// on the first clock after reset release.
module day4_scan_sequencer
   import day4_pkg::*;
#(
   parameter int CAND_W = DAY4_CAND_W,
   parameter int CNT_W  = DAY4_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CAND_W-1:0] range_lo,
   input  logic [CAND_W-1:0] range_hi,
   output logic [CAND_W-1:0] cand,
   output logic              cand_valid,
   input  logic              cand_ready,
   input  logic              res_valid,
   input  logic              res_pass,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [CNT_W-1:0]  pass_count
);

   scan_state_t       state, state_nxt;
   logic [CAND_W-1:0] cur;
   logic [CAND_W-1:0] hi;
   logic              launch;
   logic              range_bad;

   // Saturating increment: the count sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a,
                                                 input logic inc);
      if (inc && (a != {CNT_W{1'b1}})) return a + CNT_W'(1);
      else                              return a;
   endfunction

`ifdef SCAN_AUTOSTART_EN
   logic first_tick;

   first_tick_pulse u_first_tick (
      .clk   (clk),
      .rst   (rst),
      .pulse (first_tick)
   );

   assign launch = start | first_tick;
`else
   assign launch = start;
`endif

   assign range_bad = (range_lo > range_hi);

   // State register; reset aborts any sweep in progress.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state decode and state-decoded outputs.
   always_comb begin
      state_nxt  = state;
      cand_valid = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE:  if (launch) state_nxt = LOAD;
         LOAD: begin
            busy      = 1'b1;
            state_nxt = range_bad ? DONE : ISSUE;
         end
         ISSUE: begin
            busy       = 1'b1;
            cand_valid = 1'b1;
            if (cand_ready) state_nxt = WAIT;
         end
         WAIT: begin
            busy = 1'b1;
            if (res_valid) state_nxt = (cur == hi) ? DONE : ISSUE;
         end
         DONE: begin
            done = 1'b1;
            if (start) state_nxt = LOAD;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Range latch, candidate walk, error flag and pass accumulation.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur        <= '0;
         hi         <= '0;
         error      <= 1'b0;
         pass_count <= '0;
      end else begin
         case (state)
            LOAD: begin
               cur        <= range_lo;
               hi         <= range_hi;
               error      <= range_bad;
               pass_count <= '0;
            end
            WAIT: begin
               if (res_valid) begin
                  pass_count <= sat_inc(pass_count, res_pass);
                  // Stop at hi so an all-ones upper bound never wraps cur.
                  if (cur != hi) cur <= cur + CAND_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign cand = cur;

endmodule

// File: tb/tb_day4_scan_sequencer.sv
// Directed bench for day4_scan_sequencer. A second instance with a 2-bit
// counter shares all inputs so count saturation can be observed.
module tb_day4_scan_sequencer;

   logic        clk = 1'b0;
   logic        rst, start, cand_ready, res_valid, res_pass;
   logic [19:0] range_lo, range_hi;
   logic [19:0] cand, pass_count, cand2;
   logic        cand_valid, busy, done, error;
   logic        cand_valid2, busy2, done2, error2;
   logic [1:0]  pass_count2;

   int total = 0;
   int bad = 0;
   logic [19:0] cands[$];
   int unstable, cv_seen, cycles;
   bit tout;

   always #5 clk = ~clk;

   day4_scan_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .range_lo(range_lo), .range_hi(range_hi),
      .cand(cand), .cand_valid(cand_valid), .cand_ready(cand_ready),
      .res_valid(res_valid), .res_pass(res_pass), .busy(busy), .done(done),
      .error(error), .pass_count(pass_count)
   );

   day4_scan_sequencer #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .start(start), .range_lo(range_lo), .range_hi(range_hi),
      .cand(cand2), .cand_valid(cand_valid2), .cand_ready(cand_ready),
      .res_valid(res_valid), .res_pass(res_pass), .busy(busy2), .done(done2),
      .error(error2), .pass_count(pass_count2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   function automatic logic pass_of(input int mode, input logic [19:0] v);
      if (mode == 0) return 1'b1;
      return (v == 20'd111111);
   endfunction

   // Plays the checker: stalls acceptance, delays results, records candidates.
   task automatic serve(input int stall, input int lat, input int mode,
                        input int budget, output int ncyc, output bit timed_out);
      int st = 0;
      int lt = 0;
      bit pend = 0;
      bit holding = 0;
      logic pv = 1'b0;
      logic [19:0] held = '0;
      timed_out = 1'b1;
      ncyc = budget;
      cands.delete();
      unstable = 0;
      cv_seen = 0;
      for (int c = 0; c < budget; c++) begin
         cand_ready = 1'b0;
         res_valid  = 1'b0;
         res_pass   = 1'b0;
         if (done) begin
            timed_out = 1'b0;
            ncyc = c;
            break;
         end
         if (cand_valid) begin
            cv_seen++;
            if (holding && cand !== held) unstable++;
            held = cand;
            holding = 1'b1;
            if (st >= stall) begin
               cand_ready = 1'b1;
               cands.push_back(cand);
               pv = pass_of(mode, cand);
               pend = 1'b1;
               lt = 0;
               st = 0;
               holding = 1'b0;
            end else st++;
         end else if (pend) begin
            if (lt >= lat) begin
               res_valid = 1'b1;
               res_pass  = pv;
               pend = 1'b0;
            end else lt++;
         end
         tick();
      end
      cand_ready = 1'b0;
      res_valid  = 1'b0;
      res_pass   = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      total++;
      if ({busy, done, cand_valid, error} !== 4'b0 || cand !== 20'd0 || pass_count !== 20'd0) begin
         bad++;
         $display("FAIL reset_values got busy=%b done=%b cv=%b err=%b cand=%0d cnt=%0d want all 0",
                  busy, done, cand_valid, error, cand, pass_count);
      end
      tick();
      rst = 1'b1;
      tick();
`ifdef SCAN_AUTOSTART_EN
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL autostart_load got busy=%b want 1", busy);
      end
      tick();
      total++;
      if (done !== 1'b1 || error !== 1'b1) begin
         bad++;
         $display("FAIL autostart_done got done=%b err=%b want 1 1", done, error);
      end
`else
      tick();
      tick();
      total++;
      if ({busy, done, cand_valid} !== 3'b0) begin
         bad++;
         $display("FAIL idle_hold got busy=%b done=%b cv=%b want 0 0 0", busy, done, cand_valid);
      end
`endif
   endtask

   task automatic test_single();
      range_lo = 20'd5;
      range_hi = 20'd5;
      launch();
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         bad++;
         $display("FAIL single_load got busy=%b done=%b want 1 0", busy, done);
      end
      serve(0, 0, 0, 50, cycles, tout);
      total++;
      if (tout || cycles != 3) begin
         bad++;
         $display("FAIL single_latency got cycles=%0d timeout=%0d want 3 0", cycles, tout);
      end
      total++;
      if (cands.size() != 1 || cands[0] !== 20'd5) begin
         bad++;
         $display("FAIL single_cand got n=%0d want one cand 5", cands.size());
      end
      total++;
      if (pass_count !== 20'd1 || error !== 1'b0) begin
         bad++;
         $display("FAIL single_result got cnt=%0d err=%b want 1 0", pass_count, error);
      end
   endtask

   task automatic test_inverted();
      range_lo = 20'd10;
      range_hi = 20'd3;
      launch();
      total++;
      if (done !== 1'b0) begin
         bad++;
         $display("FAIL inv_done_drop got done=%b want 0", done);
      end
      serve(0, 0, 0, 20, cycles, tout);
      total++;
      if (tout || cycles != 1) begin
         bad++;
         $display("FAIL inv_latency got cycles=%0d timeout=%0d want 1 0", cycles, tout);
      end
      total++;
      if (error !== 1'b1 || pass_count !== 20'd0 || cv_seen != 0) begin
         bad++;
         $display("FAIL inv_result got err=%b cnt=%0d cv_cycles=%0d want 1 0 0", error, pass_count, cv_seen);
      end
   endtask

   task automatic test_backpressure();
      range_lo = 20'd111110;
      range_hi = 20'd111112;
      launch();
      serve(4, 3, 1, 200, cycles, tout);
      total++;
      if (tout || cycles != 28) begin
         bad++;
         $display("FAIL bp_latency got cycles=%0d timeout=%0d want 28 0", cycles, tout);
      end
      total++;
      if (cands.size() != 3 || cands[0] !== 20'd111110 || cands[1] !== 20'd111111 || cands[2] !== 20'd111112) begin
         bad++;
         $display("FAIL bp_sequence got n=%0d want 111110 111111 111112", cands.size());
      end
      total++;
      if (unstable != 0) begin
         bad++;
         $display("FAIL bp_stable got changes=%0d want 0", unstable);
      end
      total++;
      if (pass_count !== 20'd1 || error !== 1'b0) begin
         bad++;
         $display("FAIL bp_count got cnt=%0d err=%b want 1 0", pass_count, error);
      end
   endtask

   task automatic test_stray();
      res_valid = 1'b1;
      res_pass  = 1'b1;
      tick();
      res_valid = 1'b0;
      res_pass  = 1'b0;
      total++;
      if (pass_count !== 20'd1 || done !== 1'b1) begin
         bad++;
         $display("FAIL stray_done_res got cnt=%0d done=%b want 1 1", pass_count, done);
      end
      range_lo = 20'd0;
      range_hi = 20'd1;
      launch();
      tick();
      res_valid = 1'b1;
      res_pass  = 1'b1;
      tick();
      res_valid = 1'b0;
      res_pass  = 1'b0;
      total++;
      if (pass_count !== 20'd0 || cand_valid !== 1'b1) begin
         bad++;
         $display("FAIL stray_issue_res got cnt=%0d cv=%b want 0 1", pass_count, cand_valid);
      end
      cand_ready = 1'b1;
      tick();
      cand_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if (busy !== 1'b1 || cand_valid !== 1'b0 || done !== 1'b0 || cand !== 20'd0) begin
         bad++;
         $display("FAIL stray_wait_start got busy=%b cv=%b done=%b cand=%0d want 1 0 0 0",
                  busy, cand_valid, done, cand);
      end
      res_valid = 1'b1;
      res_pass  = 1'b1;
      tick();
      res_valid = 1'b0;
      res_pass  = 1'b0;
      serve(0, 0, 0, 20, cycles, tout);
      total++;
      if (tout || pass_count !== 20'd2 || cands.size() != 1 || cands[0] !== 20'd1) begin
         bad++;
         $display("FAIL stray_rerun got cnt=%0d n=%0d timeout=%0d want 2 1 0", pass_count, cands.size(), tout);
      end
   endtask

   task automatic test_saturation();
      range_lo = 20'd0;
      range_hi = 20'd7;
      launch();
      serve(0, 0, 0, 100, cycles, tout);
      total++;
      if (tout || cycles != 17 || cands.size() != 8 || cands[7] !== 20'd7) begin
         bad++;
         $display("FAIL sat_sweep got cycles=%0d n=%0d timeout=%0d want 17 8 0", cycles, cands.size(), tout);
      end
      total++;
      if (pass_count !== 20'd8) begin
         bad++;
         $display("FAIL sat_wide_count got %0d want 8", pass_count);
      end
      total++;
      if (pass_count2 !== 2'd3 || done2 !== 1'b1) begin
         bad++;
         $display("FAIL sat_narrow got cnt=%0d done=%b want 3 1", pass_count2, done2);
      end
   endtask

   task automatic test_reset_mid();
      range_lo = 20'd0;
      range_hi = 20'd100;
      launch();
      tick();
      for (int k = 0; k < 3; k++) begin
         cand_ready = 1'b1;
         tick();
         cand_ready = 1'b0;
         res_valid  = 1'b1;
         res_pass   = 1'b1;
         tick();
         res_valid  = 1'b0;
         res_pass   = 1'b0;
      end
      cand_ready = 1'b1;
      tick();
      cand_ready = 1'b0;
      total++;
      if (busy !== 1'b1 || cand_valid !== 1'b0 || pass_count !== 20'd3 || cand !== 20'd3) begin
         bad++;
         $display("FAIL mid_wait got busy=%b cv=%b cnt=%0d cand=%0d want 1 0 3 3",
                  busy, cand_valid, pass_count, cand);
      end
      #2;
      rst = 1'b0;
      #1;
      total++;
      if ({busy, done, cand_valid, error} !== 4'b0 || cand !== 20'd0 || pass_count !== 20'd0
          || pass_count2 !== 2'd0) begin
         bad++;
         $display("FAIL mid_async_reset got busy=%b done=%b cv=%b err=%b cand=%0d cnt=%0d want all 0",
                  busy, done, cand_valid, error, cand, pass_count);
      end
      range_lo = 20'd5;
      range_hi = 20'd5;
      tick();
      rst = 1'b1;
      tick();
`ifdef SCAN_AUTOSTART_EN
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL mid_release got busy=%b want 1", busy);
      end
`else
      tick();
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL mid_release got busy=%b done=%b want 0 0", busy, done);
      end
`endif
   endtask

   initial begin
      rst        = 1'b0;
      start      = 1'b0;
      cand_ready = 1'b0;
      res_valid  = 1'b0;
      res_pass   = 1'b0;
      range_lo   = 20'd1;
      range_hi   = 20'd0;
      test_reset();
      test_single();
      test_inverted();
      test_backpressure();
      test_stray();
      test_saturation();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
